// File: rtl/ep_alu_seq.sv
// Multi-channel shared ALU: snapshots NCH operand pairs on start and processes one channel per okClk.
// Latency: channel k written at E0+1+k; done pulses in the cycle after edge E0+NCH (start-to-done NCH+1 cycles).
// Backpressure: none; a start while RUN/FIN is dropped and recorded in the sticky start_dropped flag.
module ep_alu_seq #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4
) (
  input  logic                 okClk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic                 sat_en,
  input  logic [NCH*WIDTH-1:0] op_a,
  input  logic [NCH*WIDTH-1:0] op_b,
  output logic [NCH*WIDTH-1:0] result,
  output logic [NCH-1:0]       ovf,
  output logic                 busy,
  output logic                 done,
  output logic                 start_dropped
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_MAX = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [IW-1:0]        r_idx;
  logic [1:0]           r_op;
  logic                 r_sat;
  logic [NCH*WIDTH-1:0] r_a;
  logic [NCH*WIDTH-1:0] r_b;
  logic [NCH*WIDTH-1:0] r_result;
  logic [NCH-1:0]       r_ovf;
  logic                 r_drop;

  logic                 w_accept;
  logic [WIDTH-1:0]     w_a;
  logic [WIDTH-1:0]     w_b;
  logic [WIDTH-1:0]     w_acc;
  logic [WIDTH:0]       w_sum_ab;
  logic [WIDTH:0]       w_sum_acc;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_res;
  logic                 w_ovf;

  // Only an idle block takes a new request; anything else is dropped.
  assign w_accept = start && (r_state == S_IDLE);

  // Current channel operands come from the snapshot; the accumulator is the live result register.
  assign w_a   = r_a[r_idx*WIDTH +: WIDTH];
  assign w_b   = r_b[r_idx*WIDTH +: WIDTH];
  assign w_acc = r_result[r_idx*WIDTH +: WIDTH];

  // Carry/borrow come from the extra MSB of the WIDTH+1 bit computations.
  assign w_sum_ab  = {1'b0, w_a} + {1'b0, w_b};
  assign w_sum_acc = {1'b0, w_acc} + {1'b0, w_a};
  assign w_diff    = {1'b0, w_a} - {1'b0, w_b};

  // FSM state register.
  always_ff @(posedge okClk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state: one RUN cycle per channel, then a single FIN cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_idx == LAST_IDX) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Shared ALU: one channel result plus its overflow flag, wrap or saturate.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_ovf = w_sum_ab[WIDTH];
        w_res = (w_sum_ab[WIDTH] && r_sat) ? '1 : w_sum_ab[WIDTH-1:0];
      end
      OP_SUB: begin
        w_ovf = w_diff[WIDTH];
        w_res = (w_diff[WIDTH] && r_sat) ? '0 : w_diff[WIDTH-1:0];
      end
      OP_ACC: begin
        w_ovf = w_sum_acc[WIDTH];
        w_res = (w_sum_acc[WIDTH] && r_sat) ? '1 : w_sum_acc[WIDTH-1:0];
      end
      OP_MAX: begin
        w_ovf = 1'b0;
        w_res = (w_a >= w_b) ? w_a : w_b;
      end
      default: begin
        w_ovf = 1'b0;
        w_res = '0;
      end
    endcase
  end

  // Snapshot of the request so later input changes cannot disturb a pass.
  always_ff @(posedge okClk) begin
    if (reset) begin
      r_op  <= '0;
      r_sat <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (w_accept) begin
      r_op  <= op;
      r_sat <= sat_en;
      r_a   <= op_a;
      r_b   <= op_b;
    end
  end

  // Channel index and sticky dropped-start flag.
  always_ff @(posedge okClk) begin
    if (reset) begin
      r_idx  <= '0;
      r_drop <= 1'b0;
    end else begin
      if (start && (r_state != S_IDLE)) begin
        r_drop <= 1'b1;
      end
      if (w_accept) begin
        r_idx  <= '0;
        r_drop <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Per-channel result and overflow write-back; untouched channels hold.
  always_ff @(posedge okClk) begin
    if (reset) begin
      r_result <= '0;
      r_ovf    <= '0;
    end else if (r_state == S_RUN) begin
      r_result[r_idx*WIDTH +: WIDTH] <= w_res;
      r_ovf[r_idx]                   <= w_ovf;
    end
  end

  assign result        = r_result;
  assign ovf           = r_ovf;
  assign busy          = (r_state == S_RUN);
  assign done          = (r_state == S_FIN);
  assign start_dropped = r_drop;

endmodule

// File: tb/tb_ep_alu_seq.sv
// Bench for ep_alu_seq: 32-bit x4 instance checked every cycle against a pass-level model, plus an 8-bit x1 instance.
// Latency: inputs change on negedge, model and DUT advance on posedge, outputs compared on negedge.
// Backpressure: stray starts are injected during passes and must be dropped without disturbing them.
module tb_ep_alu_seq;

  localparam int W = 32;
  localparam int N = 4;
  localparam longint unsigned MAXV = 64'hFFFF_FFFF;
  localparam longint unsigned TOP  = 64'h1_0000_0000;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [1:0]     op;
  logic           sat_en;
  logic [N*W-1:0] op_a;
  logic [N*W-1:0] op_b;
  logic [N*W-1:0] result;
  logic [N-1:0]   ovf;
  logic           busy;
  logic           done;
  logic           start_dropped;

  logic           sm_start;
  logic [1:0]     sm_op;
  logic           sm_sat;
  logic [7:0]     sm_a;
  logic [7:0]     sm_b;
  logic [7:0]     sm_result;
  logic [0:0]     sm_ovf;
  logic           sm_busy;
  logic           sm_done;
  logic           sm_drop;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  ep_alu_seq #(.WIDTH(W), .NCH(N)) u_dut (
    .okClk(clk), .reset(reset), .start(start), .op(op), .sat_en(sat_en),
    .op_a(op_a), .op_b(op_b), .result(result), .ovf(ovf),
    .busy(busy), .done(done), .start_dropped(start_dropped)
  );

  ep_alu_seq #(.WIDTH(8), .NCH(1)) u_small (
    .okClk(clk), .reset(reset), .start(sm_start), .op(sm_op), .sat_en(sm_sat),
    .op_a(sm_a), .op_b(sm_b), .result(sm_result), .ovf(sm_ovf),
    .busy(sm_busy), .done(sm_done), .start_dropped(sm_drop)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // ---------------- pass-level reference model ----------------
  longint unsigned m_res [N];
  bit              m_ovf [N];
  longint unsigned m_sa  [N];
  longint unsigned m_sb  [N];
  int              m_sop;
  bit              m_ssat;
  bit              m_active;
  bit              m_fin;
  bit              m_drop;
  bit              m_was_idle;
  int              m_t;
  longint unsigned m_r;
  bit              m_f;

  function automatic void model_alu(input int o, input bit s, input longint unsigned a,
                                    input longint unsigned b, input longint unsigned acc,
                                    output longint unsigned r, output bit f);
    case (o)
      0: begin r = a + b; f = (r > MAXV); if (f) r = s ? MAXV : r - TOP; end
      1: begin f = (a < b); r = f ? (s ? 64'd0 : a + TOP - b) : a - b; end
      2: begin r = acc + a; f = (r > MAXV); if (f) r = s ? MAXV : r - TOP; end
      default: begin r = (a >= b) ? a : b; f = 1'b0; end
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        m_res[k] = 0;
        m_ovf[k] = 1'b0;
      end
      m_active = 1'b0;
      m_fin    = 1'b0;
      m_drop   = 1'b0;
      m_t      = 0;
    end else begin
      m_was_idle = !m_active && !m_fin;
      m_fin = 1'b0;
      if (m_active) begin
        model_alu(m_sop, m_ssat, m_sa[m_t], m_sb[m_t], m_res[m_t], m_r, m_f);
        m_res[m_t] = m_r;
        m_ovf[m_t] = m_f;
        m_t++;
        if (m_t == N) begin
          m_active = 1'b0;
          m_fin    = 1'b1;
        end
      end
      if (start) begin
        if (m_was_idle) begin
          for (int k = 0; k < N; k++) begin
            m_sa[k] = op_a[k*W +: W];
            m_sb[k] = op_b[k*W +: W];
          end
          m_sop    = int'(op);
          m_ssat   = sat_en;
          m_active = 1'b1;
          m_t      = 0;
          m_drop   = 1'b0;
        end else begin
          m_drop = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    logic [N*W-1:0] ev;
    logic [N-1:0]   eo;
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        ev[k*W +: W] = m_res[k][W-1:0];
        eo[k]        = m_ovf[k];
      end
      chk("cyc_result", result, ev);
      chk("cyc_ovf", {124'd0, ovf}, {124'd0, eo});
      chk("cyc_busy", {127'd0, busy}, {127'd0, m_active});
      chk("cyc_done", {127'd0, done}, {127'd0, m_fin});
      chk("cyc_dropped", {127'd0, start_dropped}, {127'd0, m_drop});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_ops(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3);
    op_a = {a3, a2, a1, a0};
    op_b = {b3, b2, b1, b0};
  endtask

  task automatic kick(input logic [1:0] o, input bit s);
    @(negedge clk);
    op     = o;
    sat_en = s;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom % 4)
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'hFFFF_FFF0 | 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  task automatic small_pass(input logic [1:0] o, input bit s, input logic [7:0] a, input logic [7:0] b,
                            output int lat);
    @(negedge clk);
    sm_op = o; sm_sat = s; sm_a = a; sm_b = b; sm_start = 1'b1;
    @(negedge clk);
    sm_start = 1'b0;
    lat = 1;
    while (!sm_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int lat, bc;
    bit seen;
    logic [31:0] v;
    reset = 1'b1; start = 1'b0; op = 2'b00; sat_en = 1'b0; op_a = '0; op_b = '0;
    sm_start = 1'b0; sm_op = 2'b00; sm_sat = 1'b0; sm_a = '0; sm_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", result, '0);
    chk("rst_ovf", {124'd0, ovf}, '0);
    chk("rst_busy_done_drop", {125'd0, busy, done, start_dropped}, '0);
    chk_en = 1'b1;
    reset  = 1'b0;

    // add, wrap
    set_ops(32'd1, 32'hFFFF_FFFF, 32'd10, 32'd0, 32'd2, 32'd1, 32'd5, 32'd0);
    kick(2'b00, 1'b0);
    wait_done(lat, bc);
    chk("add_latency", lat, 5);
    chk("add_busy_cycles", bc, 4);
    chk("add_result", result, {32'd0, 32'd15, 32'd0, 32'd3});
    chk("add_ovf", {124'd0, ovf}, 4'b0010);
    @(negedge clk);
    chk("add_done_one_cycle", {127'd0, done}, '0);

    // sub, saturate then wrap
    set_ops(32'd5, 32'd3, 32'd0, 32'd0, 32'd3, 32'd7, 32'd0, 32'd0);
    kick(2'b01, 1'b1);
    wait_done(lat, bc);
    chk("sub_sat_result", result, {32'd0, 32'd0, 32'd0, 32'd2});
    chk("sub_sat_ovf", {124'd0, ovf}, 4'b0010);
    kick(2'b01, 1'b0);
    wait_done(lat, bc);
    chk("sub_wrap_result", result, {32'd0, 32'd0, 32'hFFFF_FFFC, 32'd2});
    chk("sub_wrap_ovf", {124'd0, ovf}, 4'b0010);

    // accumulate, saturating then wrapping
    for (int s = 1; s >= 0; s--) begin
      do_reset();
      set_ops(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'd0, 32'd0, 32'd0, 32'd0);
      for (int p = 1; p <= 4; p++) begin
        kick(2'b10, s[0]);
        wait_done(lat, bc);
        v = (p < 4) ? 32'h4000_0000 * p : (s != 0 ? 32'hFFFF_FFFF : 32'h0);
        chk($sformatf("acc_s%0d_p%0d_result", s, p), result, {v, v, v, v});
        chk($sformatf("acc_s%0d_p%0d_ovf", s, p), {124'd0, ovf}, (p == 4) ? 4'b1111 : 4'b0000);
      end
    end

    // dropped start during RUN, operand change after the snapshot edge
    set_ops(32'd11, 32'd22, 32'd33, 32'd44, 32'd1, 32'd2, 32'd3, 32'd4);
    kick(2'b00, 1'b0);
    op_a = {4{32'd99}};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("drop_flag_set", {127'd0, start_dropped}, 1);
    wait_done(lat, bc);
    chk("snapshot_result", result, {32'd48, 32'd36, 32'd24, 32'd12});
    chk("drop_flag_sticky", {127'd0, start_dropped}, 1);
    kick(2'b11, 1'b0);
    chk("drop_flag_cleared", {127'd0, start_dropped}, 0);
    wait_done(lat, bc);

    // reset mid-pass aborts without done
    set_ops(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8);
    kick(2'b00, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_result", result, '0);
    chk("midrst_flags", {124'd0, ovf}, '0);
    chk("midrst_busy_done", {126'd0, busy, done}, '0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", {127'd0, seen}, 0);
    set_ops(32'd7, 32'd8, 32'd9, 32'd10, 32'd1, 32'd1, 32'd1, 32'd1);
    kick(2'b00, 1'b0);
    wait_done(lat, bc);
    chk("after_rst_latency", lat, 5);
    chk("after_rst_result", result, {32'd11, 32'd10, 32'd9, 32'd8});

    // random passes with stray starts and input churn
    for (int it = 0; it < 40; it++) begin
      set_ops(rnd32(), rnd32(), rnd32(), rnd32(), rnd32(), rnd32(), rnd32(), rnd32());
      kick(2'($urandom % 4), 1'($urandom % 2));
      lat = 1;
      while (!done && lat < 40) begin
        start = (($urandom % 5) == 0);
        op    = 2'($urandom % 4);
        op_a  = {rnd32(), rnd32(), rnd32(), rnd32()};
        op_b  = {rnd32(), rnd32(), rnd32(), rnd32()};
        @(negedge clk);
        lat++;
      end
      start = 1'b0;
      chk("rnd_latency", lat, 5);
    end

    // 8-bit single-channel instance
    small_pass(2'b11, 1'b0, 8'h80, 8'h7F, lat);
    chk("sm_max_latency", lat, 2);
    chk("sm_max_result", {120'd0, sm_result}, 8'h80);
    chk("sm_max_ovf", {127'd0, sm_ovf}, 0);
    small_pass(2'b00, 1'b1, 8'hF0, 8'h20, lat);
    chk("sm_add_sat", {119'd0, sm_ovf, sm_result}, {1'b1, 8'hFF});
    small_pass(2'b00, 1'b0, 8'hF0, 8'h20, lat);
    chk("sm_add_wrap", {119'd0, sm_ovf, sm_result}, {1'b1, 8'h10});
    small_pass(2'b01, 1'b0, 8'h7F, 8'h80, lat);
    chk("sm_sub_wrap", {119'd0, sm_ovf, sm_result}, {1'b1, 8'hFF});
    @(negedge clk);
    chk("sm_idle", {126'd0, sm_busy, sm_done}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
